// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP header parser slice.
package udp_pkg;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] len;
    logic [15:0] csum;
  } udp_hdr_t;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DROP = 2'd2
  } parse_state_t;

  localparam int UDP_HDR_WORDS = 4;
  localparam int UDP_HDR_BYTES = 8;

  // Payload words implied by the length field, rounded up. 17 bits so a
  // short length cannot wrap into a plausible count.
  function automatic logic [16:0] exp_words(input logic [15:0] len);
    exp_words = ({1'b0, len} - 17'(UDP_HDR_BYTES) + 17'd1) >> 1;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered AXI-stream stage carrying 16-bit data plus last.
module axis_reg_slice (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last
);

  // Handshake: a beat moves when valid && ready at a clk edge; valid does not
  // wait for ready, and the holder keeps data stable until it moves.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 16'd0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/udp_hdr_parser.sv
// UDP header parser: splits the four header words off a 16-bit stream and
// forwards the payload. Optional destination-port filter: UDP_PORT_FILTER_EN.
module udp_hdr_parser
  import udp_pkg::*;
#(
  parameter logic [15:0] FILTER_PORT = 16'd5000,
  parameter int          CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        hdr_valid,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_len,
  output logic [15:0] udp_csum,
`ifdef UDP_PORT_FILTER_EN
  output logic        drop_pulse,
`endif
  output logic        err_short,
  output logic        err_len
);

  localparam logic [1:0] LAST_HDR_IDX = 2'(UDP_HDR_WORDS - 1);

  parse_state_t      state;
  logic [1:0]        hdr_idx;
  logic [CNT_W-1:0]  word_cnt;
  logic [16:0]       exp_q;
  udp_hdr_t          hdr_q;
  logic [15:0]       stage_src, stage_dst, stage_len;

  logic              s_acc;
  logic              slice_in_ready;
  logic              len_short;
  logic              filter_drop;
  logic [16:0]       new_exp;
  logic [16:0]       cnt_next;

  // Header words are staged so the visible fields only change together,
  // at the hdr_valid pulse; a truncated header leaves them untouched.
  always_comb begin
    s_ready = 1'b1;
    if (state == PAY) s_ready = slice_in_ready;
  end

  assign s_acc     = s_valid && s_ready;
  assign len_short = stage_len < 16'(UDP_HDR_BYTES);
  assign new_exp   = exp_words(stage_len);
  assign cnt_next  = 17'(word_cnt) + 17'd1;

`ifdef UDP_PORT_FILTER_EN
  assign filter_drop = (stage_dst != FILTER_PORT);
`else
  assign filter_drop = 1'b0 && (stage_dst != FILTER_PORT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HDR;
      hdr_idx   <= 2'd0;
      word_cnt  <= '0;
      exp_q     <= 17'd0;
      hdr_q     <= '0;
      stage_src <= 16'd0;
      stage_dst <= 16'd0;
      stage_len <= 16'd0;
      hdr_valid <= 1'b0;
      err_short <= 1'b0;
      err_len   <= 1'b0;
`ifdef UDP_PORT_FILTER_EN
      drop_pulse <= 1'b0;
`endif
    end else begin
      hdr_valid <= 1'b0;
      err_short <= 1'b0;
      err_len   <= 1'b0;
`ifdef UDP_PORT_FILTER_EN
      drop_pulse <= 1'b0;
`endif
      case (state)
        HDR: begin
          if (s_acc) begin
            if (hdr_idx == LAST_HDR_IDX) begin
              hdr_q     <= '{src_port: stage_src, dst_port: stage_dst,
                             len: stage_len, csum: s_data};
              hdr_valid <= 1'b1;
              hdr_idx   <= 2'd0;
              exp_q     <= new_exp;
              if (len_short) begin
                err_len <= 1'b1;
                state   <= s_last ? HDR : DROP;
              end else if (filter_drop) begin
`ifdef UDP_PORT_FILTER_EN
                drop_pulse <= 1'b1;
`endif
                state <= s_last ? HDR : DROP;
              end else if (s_last) begin
                err_len <= (new_exp != 17'd0);
                state   <= HDR;
              end else begin
                state <= PAY;
              end
            end else if (s_last) begin
              err_short <= 1'b1;
              hdr_idx   <= 2'd0;
            end else begin
              case (hdr_idx)
                2'd0:    stage_src <= s_data;
                2'd1:    stage_dst <= s_data;
                default: stage_len <= s_data;
              endcase
              hdr_idx <= hdr_idx + 2'd1;
            end
          end
        end
        PAY: begin
          if (s_acc) begin
            if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
            if (s_last) begin
              err_len  <= (cnt_next != exp_q);
              word_cnt <= '0;
              hdr_idx  <= 2'd0;
              state    <= HDR;
            end
          end
        end
        DROP: begin
          if (s_acc && s_last) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

  axis_reg_slice u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_valid && (state == PAY)),
    .in_ready  (slice_in_ready),
    .in_data   (s_data),
    .in_last   (s_last),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .out_last  (m_last)
  );

  assign src_port = hdr_q.src_port;
  assign dst_port = hdr_q.dst_port;
  assign udp_len  = hdr_q.len;
  assign udp_csum = hdr_q.csum;

endmodule

// File: tb/tb_udp_hdr_parser.sv
// Scoreboard bench for udp_hdr_parser: directed packets, expectations queued
// at issue time, a negedge monitor pops and compares DUT outputs.
module tb_udp_hdr_parser;

  localparam logic [3:0] EV_HDR   = 4'b1000;
  localparam logic [3:0] EV_SHORT = 4'b0100;
  localparam logic [3:0] EV_LEN   = 4'b0010;
  localparam logic [3:0] EV_DROP  = 4'b0001;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_valid, s_ready, s_last;
  logic [15:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [15:0] m_data;
  logic        hdr_valid, err_short, err_len;
  logic [15:0] src_port, dst_port, udp_len, udp_csum;
  logic        drop_s;
`ifdef UDP_PORT_FILTER_EN
  logic        drop_pulse;
  assign drop_s = drop_pulse;
`else
  assign drop_s = 1'b0;
`endif

  udp_hdr_parser dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .hdr_valid (hdr_valid),
    .src_port  (src_port),
    .dst_port  (dst_port),
    .udp_len   (udp_len),
    .udp_csum  (udp_csum),
`ifdef UDP_PORT_FILTER_EN
    .drop_pulse(drop_pulse),
`endif
    .err_short (err_short),
    .err_len   (err_len)
  );

  // scoreboard state
  logic [16:0] exp_q[$];
  logic [63:0] hdr_q[$];
  logic [3:0]  ev_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [63:0] eh;
    logic [16:0] ep;
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("pay_unexpected", {47'd0, m_last, m_data}, 64'h1_0000_0000);
        else begin
          ep = exp_q.pop_front();
          check("pay_word", {47'd0, m_last, m_data}, {47'd0, ep});
        end
      end
      ev = {hdr_valid, err_short, err_len, drop_s};
      if (ev != 4'd0) begin
        if (ev_q.size() == 0) check("event_unexpected", {60'd0, ev}, 64'd0);
        else check("event", {60'd0, ev}, {60'd0, ev_q.pop_front()});
        if (hdr_valid) begin
          if (hdr_q.size() == 0) check("hdr_unexpected", {src_port, dst_port, udp_len, udp_csum}, 64'd0);
          else begin
            eh = hdr_q.pop_front();
            check("hdr_fields", {src_port, dst_port, udp_len, udp_csum}, eh);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic send_word(input logic [15:0] d, input logic l);
    int cyc;
    logic acc;
    s_valid = 1'b1; s_data = d; s_last = l; cyc = 0;
    do begin
      @(negedge clk); acc = s_ready;
      @(posedge clk); #1;
      cyc++;
    end while (!acc && cyc < 200);
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: word %0h not accepted, required accept within 200 cycles", d);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] a, b, c, d, input logic last_on_d);
    send_word(a, 1'b0); send_word(b, 1'b0); send_word(c, 1'b0); send_word(d, last_on_d);
  endtask

  task automatic exp_hdr(input logic [15:0] a, b, c, d, input logic [3:0] ev);
    hdr_q.push_back({a, b, c, d});
    ev_q.push_back(ev);
  endtask

  task automatic exp_pay(input logic [15:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b0; s_data = 16'd0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_m_data", {48'd0, m_data}, 64'd0);
    check("rst_pulses", {60'd0, hdr_valid, err_short, err_len, drop_s}, 64'd0);
    check("rst_fields", {src_port, dst_port, udp_len, udp_csum}, 64'd0);
    check("rst_s_ready", {63'd0, s_ready}, 64'd1);
    @(posedge clk); #1;

    // basic packet, two payload words
    exp_hdr(16'h1234, 16'h1388, 16'h000C, 16'hABCD, EV_HDR);
    exp_pay(16'hDEAD, 1'b0); exp_pay(16'hBEEF, 1'b1);
    send_hdr(16'h1234, 16'h1388, 16'h000C, 16'hABCD, 1'b0);
    send_word(16'hDEAD, 1'b0); send_word(16'hBEEF, 1'b1);

    // same packet with downstream stalled for 3 cycles after DEAD
    exp_hdr(16'h1234, 16'h1388, 16'h000C, 16'hABCD, EV_HDR);
    exp_pay(16'hDEAD, 1'b0); exp_pay(16'hBEEF, 1'b1);
    send_hdr(16'h1234, 16'h1388, 16'h000C, 16'hABCD, 1'b0);
    send_word(16'hDEAD, 1'b0);
    m_ready = 1'b0;
    fork
      send_word(16'hBEEF, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_s_ready", {63'd0, s_ready}, 64'd0);
          check("stall_hold", {47'd0, m_valid, m_data}, {47'd0, 1'b1, 16'hDEAD});
        end
        @(posedge clk); #1 m_ready = 1'b1;
      end
    join

    // truncated header, then a good packet
    ev_q.push_back(EV_SHORT);
    send_word(16'h0001, 1'b0); send_word(16'h0002, 1'b1);
    @(negedge clk);
    check("short_fields_held", {src_port, dst_port, udp_len, udp_csum},
          {16'h1234, 16'h1388, 16'h000C, 16'hABCD});
    @(posedge clk); #1;
    exp_hdr(16'h1111, 16'h1388, 16'h000A, 16'h0000, EV_HDR);
    exp_pay(16'hCAFE, 1'b1);
    send_hdr(16'h1111, 16'h1388, 16'h000A, 16'h0000, 1'b0);
    send_word(16'hCAFE, 1'b1);

    // length says 3 payload words, only 2 sent
    exp_hdr(16'h2222, 16'h1388, 16'h000E, 16'h0001, EV_HDR);
    exp_pay(16'h0A0A, 1'b0); exp_pay(16'h0B0B, 1'b1);
    ev_q.push_back(EV_LEN);
    send_hdr(16'h2222, 16'h1388, 16'h000E, 16'h0001, 1'b0);
    send_word(16'h0A0A, 1'b0); send_word(16'h0B0B, 1'b1);

    // udp_len below header size: error with hdr_valid, payload dropped
    exp_hdr(16'h0007, 16'h0008, 16'h0004, 16'h0000, EV_HDR | EV_LEN);
    send_hdr(16'h0007, 16'h0008, 16'h0004, 16'h0000, 1'b0);
    send_word(16'h1111, 1'b0); send_word(16'h2222, 1'b1);

    // header-only packets: len 8 is clean, len 9 expects one word
    exp_hdr(16'h3333, 16'h1388, 16'h0008, 16'hFFFF, EV_HDR);
    send_hdr(16'h3333, 16'h1388, 16'h0008, 16'hFFFF, 1'b1);
    exp_hdr(16'h4444, 16'h1388, 16'h0009, 16'h0000, EV_HDR | EV_LEN);
    send_hdr(16'h4444, 16'h1388, 16'h0009, 16'h0000, 1'b1);

    // odd byte length rounds up: 11 bytes -> 2 payload words
    exp_hdr(16'h5151, 16'h1388, 16'h000B, 16'h1212, EV_HDR);
    exp_pay(16'h0102, 1'b0); exp_pay(16'h0300, 1'b1);
    send_hdr(16'h5151, 16'h1388, 16'h000B, 16'h1212, 1'b0);
    send_word(16'h0102, 1'b0); send_word(16'h0300, 1'b1);

    // port 0x0050 is filtered only when the filter is built in
`ifdef UDP_PORT_FILTER_EN
    exp_hdr(16'h6666, 16'h0050, 16'h000C, 16'h0000, EV_HDR | EV_DROP);
`else
    exp_hdr(16'h6666, 16'h0050, 16'h000C, 16'h0000, EV_HDR);
    exp_pay(16'hAAAA, 1'b0); exp_pay(16'hBBBB, 1'b1);
`endif
    send_hdr(16'h6666, 16'h0050, 16'h000C, 16'h0000, 1'b0);
    send_word(16'hAAAA, 1'b0); send_word(16'hBBBB, 1'b1);

    // reset mid-header, next word is header word 0 again
    send_word(16'h9999, 1'b0); send_word(16'h8888, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_hdr(16'h5555, 16'h1388, 16'h000A, 16'h0000, EV_HDR);
    exp_pay(16'h7777, 1'b1);
    send_hdr(16'h5555, 16'h1388, 16'h000A, 16'h0000, 1'b0);
    send_word(16'h7777, 1'b1);

    repeat (10) @(posedge clk);
    check("pay_queue_empty", 64'(exp_q.size()), 64'd0);
    check("hdr_queue_empty", 64'(hdr_q.size()), 64'd0);
    check("event_queue_empty", 64'(ev_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
